fft_peak_picker: RTL

- Downstream of the FIR/FFT stage.
- Captures one 16-bin FFT frame when fft_valid pulses, then serially computes re²+im² per bin, one bin per clock.
- Reports the index of the largest-magnitude bin on freq with a one-cycle done pulse.
- Frees the FFT stage from the peak search and gives a fixed, frame-independent latency.

---
 rtl/fas_pkg.sv | 17 +
 rtl/fas_mag_sq.sv | 22 ++
 rtl/fft_peak_picker.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fas_pkg.sv
// Shared constants and FSM encoding for the FFT peak picker.
// Bin words are {re, im}, two's complement halves.
package fas_pkg;
  localparam int DW     = 16;
  localparam int NBINS  = 16;
  localparam int IDX_W  = 4;
  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } fas_state_t;
endpackage

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude re^2 + im^2 of one signed bin word.
// Both squares are non-negative; the worst case 2^31 still fits in 32 bits.
module fas_mag_sq
  import fas_pkg::*;
(
  input  logic [2*DW-1:0] bin_word,
  output logic [2*DW-1:0] mag
);
  logic [2*DW-1:0] re_x_s;
  logic [2*DW-1:0] im_x_s;
  logic [2*DW-1:0] re_sq_s;
  logic [2*DW-1:0] im_sq_s;

  // Sign-extend each half; the low 2*DW bits of the product are the exact signed square.
  always_comb begin
    re_x_s  = {{DW{bin_word[RE_MSB]}}, bin_word[RE_MSB:RE_LSB]};
    im_x_s  = {{DW{bin_word[IM_MSB]}}, bin_word[IM_MSB:IM_LSB]};
    re_sq_s = re_x_s * re_x_s;
    im_sq_s = im_x_s * im_x_s;
    mag     = re_sq_s + im_sq_s;
  end
endmodule

// File: rtl/fft_peak_picker.sv
// Captures a 16-bin FFT frame and serially finds the largest-magnitude bin.
// Fixed latency: done pulses in the cycle after the 17th edge following capture.
module fft_peak_picker
  import fas_pkg::*;
#(
  parameter int DW       = fas_pkg::DW,
  parameter int NBINS    = fas_pkg::NBINS,
  parameter int SKIP_DC  = 0,
  parameter int LAST_BIN = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [2*DW-1:0]   fft_d0,  fft_d1,  fft_d2,  fft_d3,
  input  logic [2*DW-1:0]   fft_d4,  fft_d5,  fft_d6,  fft_d7,
  input  logic [2*DW-1:0]   fft_d8,  fft_d9,  fft_d10, fft_d11,
  input  logic [2*DW-1:0]   fft_d12, fft_d13, fft_d14, fft_d15,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  freq,
  output logic [2*DW-1:0]   peak_mag,
  output logic              overrun
);
  logic [2*DW-1:0]  d_s [NBINS];
  logic [2*DW-1:0]  frame_r [NBINS];
  fas_state_t       state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, cmp_idx_r, max_idx_r, new_idx_s;
  logic [2*DW-1:0]  mag_s, mag_q_r, max_r, new_max_s;
  logic             mag_vld_r, have_r, cand_s, take_s;

  // Gather the frame ports into an indexable bank.
  always_comb begin
    d_s[0]  = fft_d0;  d_s[1]  = fft_d1;  d_s[2]  = fft_d2;  d_s[3]  = fft_d3;
    d_s[4]  = fft_d4;  d_s[5]  = fft_d5;  d_s[6]  = fft_d6;  d_s[7]  = fft_d7;
    d_s[8]  = fft_d8;  d_s[9]  = fft_d9;  d_s[10] = fft_d10; d_s[11] = fft_d11;
    d_s[12] = fft_d12; d_s[13] = fft_d13; d_s[14] = fft_d14; d_s[15] = fft_d15;
  end

  fas_mag_sq u_mag_sq (
    .bin_word (frame_r[idx_r]),
    .mag      (mag_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fft_valid) state_nxt_s = SCAN;
        else           state_nxt_s = IDLE;
      end
      SCAN: begin
        if (idx_r == IDX_W'(NBINS - 1)) state_nxt_s = FINISH;
        else                            state_nxt_s = SCAN;
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Stage-2 compare: first candidate always loads, later ones only if strictly greater.
  always_comb begin
    cand_s    = ((int'(cmp_idx_r) >= 1) || (SKIP_DC == 0)) && (int'(cmp_idx_r) <= LAST_BIN);
    take_s    = mag_vld_r && cand_s && (!have_r || (mag_q_r > max_r));
    new_max_s = max_r;
    new_idx_s = max_idx_r;
    if (take_s) begin
      new_max_s = mag_q_r;
      new_idx_s = cmp_idx_r;
    end else begin
      new_max_s = max_r;
      new_idx_s = max_idx_r;
    end
  end

  // State, pipeline, running max and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      cmp_idx_r <= '0;
      mag_q_r   <= '0;
      mag_vld_r <= 1'b0;
      max_r     <= '0;
      max_idx_r <= '0;
      have_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      freq      <= '0;
      peak_mag  <= '0;
      overrun   <= 1'b0;
      for (int i = 0; i < NBINS; i++) frame_r[i] <= '0;
    end else begin
      state_r   <= state_nxt_s;
      done      <= 1'b0;
      mag_q_r   <= mag_s;
      cmp_idx_r <= idx_r;
      mag_vld_r <= (state_r == SCAN);
      max_r     <= new_max_s;
      max_idx_r <= new_idx_s;
      have_r    <= have_r | take_s;
      if (fft_valid && (state_r != IDLE)) overrun <= 1'b1;
      case (state_r)
        IDLE: begin
          if (fft_valid) begin
            for (int i = 0; i < NBINS; i++) frame_r[i] <= d_s[i];
            busy      <= 1'b1;
            idx_r     <= '0;
            have_r    <= 1'b0;
            max_r     <= '0;
            max_idx_r <= '0;
          end
        end
        SCAN: idx_r <= idx_r + IDX_W'(1);
        FINISH: begin
          freq     <= new_idx_s;
          peak_mag <= new_max_s;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end
endmodule
